// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM for a multicycle RV32 core. Steps each
//               instruction through fetch, decode, execute, memory and
//               writeback using one shared ALU, one unified memory and the
//               immediate extend unit. Stalls on MemReady_i. Counts retired
//               instructions. Traps illegal instructions into a sticky error
//               state that only reset can leave.
// Ports       : clk_i, rst_i (async, active high)
//               op_i/funct3_i/funct7b5_i - instruction fields
//               Zero_i        - ALU zero flag, used for the branch decision
//               MemReady_i    - memory access completes this cycle
//               ImmSrc_o      - extend select, decoded from op_i
//               PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o,
//               ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegWrite_o - datapath control
//               Illegal_o     - sticky illegal-instruction flag
//               RetireCount_o - retired-instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int COUNTW = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [6:0]        op_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7b5_i,
    input  logic              Zero_i,
    input  logic              MemReady_i,
    output logic [2:0]        ImmSrc_o,
    output logic              PCWrite_o,
    output logic              AdrSrc_o,
    output logic              MemWrite_o,
    output logic              IRWrite_o,
    output logic [1:0]        ResultSrc_o,
    output logic [1:0]        ALUSrcA_o,
    output logic [1:0]        ALUSrcB_o,
    output logic [1:0]        ALUOp_o,
    output logic              RegWrite_o,
    output logic              Illegal_o,
    output logic [COUNTW-1:0] RetireCount_o
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_LUI      = 4'd8,
        S_JAL      = 4'd9,
        S_ALUWB    = 4'd10,
        S_BEQ      = 4'd11,
        S_ERROR    = 4'd12
    } state_t;

    // Per-state control bits. fetch/branch mark the two states whose PC and
    // IR enables are qualified by live inputs rather than being pure Moore.
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       pc_write;
        logic       illegal;
        logic       fetch;
        logic       branch;
    } ctrl_t;

    function automatic ctrl_t f_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.fetch      = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_LUI: begin
                c.alu_src_a = 2'b11;
                c.alu_src_b = 2'b01;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_write  = 1'b1;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            S_ERROR: begin
                c.illegal = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    state_t              r_state_q;
    state_t              w_state_d;
    ctrl_t               r_ctrl_q;
    logic [COUNTW-1:0]   r_count_q;
    logic [COUNTW-1:0]   w_count_d;
    logic                w_retire;

    // ALU-level funct7 decode lives in the ALU decoder, not here.
    logic w_unused_funct7b5;
    assign w_unused_funct7b5 = funct7b5_i;

    always_comb begin
        w_state_d = r_state_q;
        w_retire  = 1'b0;
        case (r_state_q)
            S_FETCH: begin
                if (MemReady_i) w_state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op_i)
                    c_OP_LOAD,
                    c_OP_STORE:  w_state_d = S_MEMADR;
                    c_OP_RTYPE:  w_state_d = S_EXECUTER;
                    c_OP_ITYPE:  w_state_d = S_EXECUTEI;
                    // Only beq (000) and bne (001) are supported.
                    c_OP_BRANCH: w_state_d = (funct3_i[2:1] == 2'b00) ? S_BEQ : S_ERROR;
                    c_OP_JAL:    w_state_d = S_JAL;
                    c_OP_LUI:    w_state_d = S_LUI;
                    default:     w_state_d = S_ERROR;
                endcase
            end
            // op bit 5 separates store from load.
            S_MEMADR:   w_state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (MemReady_i) w_state_d = S_MEMWB;
            end
            S_MEMWB: begin
                w_state_d = S_FETCH;
                w_retire  = 1'b1;
            end
            S_MEMWRITE: begin
                if (MemReady_i) begin
                    w_state_d = S_FETCH;
                    w_retire  = 1'b1;
                end
            end
            S_EXECUTER,
            S_EXECUTEI,
            S_LUI,
            S_JAL:      w_state_d = S_ALUWB;
            S_ALUWB,
            S_BEQ: begin
                w_state_d = S_FETCH;
                w_retire  = 1'b1;
            end
            S_ERROR:    w_state_d = S_ERROR;
            default:    w_state_d = S_FETCH;
        endcase
        w_count_d = w_retire ? (r_count_q + COUNTW'(1)) : r_count_q;
    end

    // Control bits are registered alongside the state, decoded from the
    // next state, so they are glitch-free copies of the state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q <= S_FETCH;
            r_ctrl_q  <= f_decode(S_FETCH);
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ctrl_q  <= f_decode(w_state_d);
            r_count_q <= w_count_d;
        end
    end

    always_comb begin
        case (op_i)
            c_OP_LOAD,
            c_OP_ITYPE:  ImmSrc_o = 3'b000;
            c_OP_STORE:  ImmSrc_o = 3'b001;
            c_OP_BRANCH: ImmSrc_o = 3'b010;
            c_OP_LUI:    ImmSrc_o = 3'b011;
            c_OP_JAL:    ImmSrc_o = 3'b100;
            default:     ImmSrc_o = 3'b000;
        endcase
    end

    // Write enables are masked by rst_i so nothing is written while reset is
    // held, even in the cycle the asynchronous reset lands.
    // funct3[0] selects bne (take when not zero) over beq (take when zero).
    assign PCWrite_o   = ~rst_i & (r_ctrl_q.pc_write
                                 | (r_ctrl_q.fetch  & MemReady_i)
                                 | (r_ctrl_q.branch & (Zero_i ^ funct3_i[0])));
    assign IRWrite_o   = ~rst_i & r_ctrl_q.fetch & MemReady_i;
    assign MemWrite_o  = ~rst_i & r_ctrl_q.mem_write;
    assign RegWrite_o  = ~rst_i & r_ctrl_q.reg_write;
    assign AdrSrc_o    = r_ctrl_q.adr_src;
    assign ResultSrc_o = r_ctrl_q.result_src;
    assign ALUSrcA_o   = r_ctrl_q.alu_src_a;
    assign ALUSrcB_o   = r_ctrl_q.alu_src_b;
    assign ALUOp_o     = r_ctrl_q.alu_op;
    assign Illegal_o   = r_ctrl_q.illegal;
    assign RetireCount_o = r_count_q;

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32 core.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU, one unified memory and the immediate extend unit.
- Drives the extend unit's ImmSrc select and all datapath mux selects and write enables.
- Stalls on a memory-ready handshake, counts retired instructions, and traps illegal instructions into a sticky error state.

Parameters:
COUNTW, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
op_i  in  7  opcode from instruction register, bits [6:0]
funct3_i  in  3  instruction bits [14:12]
funct7b5_i  in  1  instruction bit 30
Zero_i  in  1  ALU zero flag
MemReady_i  in  1  memory access completes this cycle
ImmSrc_o  out  3  extend select: 000 I, 001 S, 010 B, 011 U, 100 J
PCWrite_o  out  1  PC register enable
AdrSrc_o  out  1  memory address select: 0 PC, 1 ALUOut
MemWrite_o  out  1  memory write strobe
IRWrite_o  out  1  instruction and OldPC register enable
ResultSrc_o  out  2  00 ALUOut, 01 read data, 10 ALUResult
ALUSrcA_o  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
ALUSrcB_o  out  2  00 RD2, 01 ImmExt, 10 constant 4
ALUOp_o  out  2  00 add, 01 subtract (branch compare), 10 decode funct3/funct7
RegWrite_o  out  1  register file write enable
Illegal_o  out  1  sticky illegal-instruction flag
RetireCount_o  out  COUNTW  retired-instruction count

Behaviour:
- Reset (async, rst_i=1):
  - State goes to FETCH; RetireCount_o=0; Illegal_o=0.
  - While rst_i is high, PCWrite_o, IRWrite_o, MemWrite_o and RegWrite_o are forced to 0.
- Output structure:
  - Outputs are a Moore decode of the state register, except for the gated enables below.
  - Unlisted selects default to 00/0; unlisted enables are 0.
- ImmSrc_o decodes op_i combinationally in every state:
  - 0000011, 0010011 → 000; 0100011 → 001; 1100011 → 010; 0110111 → 011; 1101111 → 100; any other opcode → 000.
- States and outputs:
  - FETCH: AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite equal MemReady_i. Go to DECODE when MemReady_i=1, otherwise hold.
  - DECODE: SrcA=01, SrcB=01, ALUOp=00; ALUOut latches the branch/JAL target. Next state by op_i:
    - lw, sw → MEMADR
    - R-type → EXECUTER
    - I-ALU → EXECUTEI
    - branch → BEQ, only if funct3 is 000 or 001; otherwise ERROR
    - jal → JAL
    - lui → LUI
    - anything else → ERROR
  - MEMADR: SrcA=10, SrcB=01, ALUOp=00. Go to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady_i=1, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH (retire).
  - MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=1 in every cycle spent here. Hold until MemReady_i=1, then go to FETCH (retire).
  - EXECUTER: SrcA=10, SrcB=00, ALUOp=10 → ALUWB.
  - EXECUTEI: SrcA=10, SrcB=01, ALUOp=10 → ALUWB.
  - LUI: SrcA=11, SrcB=01, ALUOp=00 → ALUWB.
  - JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH (retire).
  - BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00. PCWrite = Zero_i when funct3=000, ~Zero_i when funct3=001. → FETCH (retire).
  - ERROR: all enables 0; Illegal_o=1; no exit except reset.
- Retirement: RetireCount_o increments by 1, with modulo wrap, on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It does not increment on a stall or on reset.
- Latency: R/I/LUI take 4 cycles, JAL 4, branch 3, sw 4, lw 5 (minimum, with MemReady_i=1 throughout).
- Reset mid-operation (including mid-stall): the FSM returns to FETCH immediately and no pending write completes.

Test Plan:
- add (op 0110011), MemReady_i=1 → FETCH, DECODE, EXECUTER, ALUWB. RegWrite_o=1 only in ALUWB. RetireCount_o goes 0→1 on the return to FETCH.
- lw with MemReady_i low for 3 cycles in MEMREAD → the FSM stays in MEMREAD 4 cycles with AdrSrc_o=1. MEMWB then asserts RegWrite_o with ResultSrc_o=01. Total 8 cycles.
- beq, funct3=000:
  - Zero_i=1 → PCWrite_o=1 in BEQ, ImmSrc_o=010.
  - bne with Zero_i=1 → PCWrite_o=0.
  - funct3=100 → ERROR.
- jal → ImmSrc_o=100 in DECODE. JAL state asserts PCWrite_o=1 with SrcA=01, SrcB=10, followed by ALUWB. sw → ImmSrc_o=001, and MemWrite_o is high only in MEMWRITE.
- op_i=1111111 → ERROR. Illegal_o stays 1 for 20 cycles regardless of inputs, with no enables asserted. rst_i pulse → FETCH, Illegal_o=0.
- COUNTW=4: after 16 retirements RetireCount_o wraps to 0. Asserting rst_i during a MEMWRITE stall → MemWrite_o drops in the same cycle and the count clears to 0.
